// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, hazard FSM states
// and the hard-wired zero register number.
package cpu_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; updates on the
// falling clock edge like the pipeline registers it observes.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ex_hazard_unit.sv
// ID/EX-side hazard control: load-use stall, taken-branch flush sequencing,
// EX operand forwarding selects and saturating stall/flush event counters.
module ex_hazard_unit
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rs,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_mem_reg_write,
    input  logic [4:0]       ex_mem_rd,
    input  logic             mem_wb_reg_write,
    input  logic [4:0]       mem_wb_rd,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             flush_active,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int RW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    hz_state_t      r_state, w_next_state;
    logic [RW-1:0]  r_rem, w_next_rem;
    logic           w_load_use, w_in_flush, w_branch, w_stall;

    assign w_load_use = id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
                        ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

    // While flushing, ID and EX hold squashed instructions, so their hazards are ignored.
    assign w_in_flush = (r_state == FLUSH);
    assign w_branch   = !w_in_flush && ex_branch_taken;
    assign w_stall    = !w_in_flush && !ex_branch_taken && w_load_use;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_rem;
        case (r_state)
            RUN: begin
                if (w_branch && (FLUSH_CYCLES > 1)) begin
                    w_next_state = FLUSH;
                    w_next_rem   = RW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (r_rem == RW'(1)) begin
                    w_next_state = RUN;
                end else begin
                    w_next_rem = r_rem - 1'b1;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign pc_write     = reset || !w_stall;
    assign if_id_write  = reset || !w_stall;
    assign if_id_flush  = !reset && (w_in_flush || w_branch);
    assign id_ex_bubble = !reset && (w_in_flush || w_branch || w_stall);
    assign flush_active = !reset && w_in_flush;

    always_comb begin
        fwd_a = FWD_REGFILE;
        fwd_b = FWD_REGFILE;
        if (!reset) begin
            if (ex_mem_reg_write && (ex_mem_rd != REG_ZERO) && (ex_mem_rd == id_ex_rs))
                fwd_a = FWD_EXMEM;
            else if (mem_wb_reg_write && (mem_wb_rd != REG_ZERO) && (mem_wb_rd == id_ex_rs))
                fwd_a = FWD_MEMWB;
            if (ex_mem_reg_write && (ex_mem_rd != REG_ZERO) && (ex_mem_rd == id_ex_rt))
                fwd_b = FWD_EXMEM;
            else if (mem_wb_reg_write && (mem_wb_rd != REG_ZERO) && (mem_wb_rd == id_ex_rt))
                fwd_b = FWD_MEMWB;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_branch),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_ex_hazard_unit.sv
// Directed bench for ex_hazard_unit: stall, flush, forwarding, async reset and
// counter saturation (second instance with 2-bit counters).
module tb_ex_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
    logic       id_uses_rt, id_ex_mem_read, ex_branch_taken;
    logic       ex_mem_reg_write, mem_wb_reg_write;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, flush_active;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_flush_active;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .flush_active(flush_active), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ex_hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_bubble(s_id_ex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .flush_active(s_flush_active), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Move past the falling (active) edge and sample 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic on);
        id_ex_mem_read = on;
        id_ex_rt       = 5'd5;
        id_rs          = 5'd5;
        id_rt          = 5'd0;
        id_uses_rt     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        id_ex_mem_read = 1'b0; id_ex_rs = '0; id_ex_rt = '0;
        ex_branch_taken = 1'b0;
        ex_mem_reg_write = 1'b0; ex_mem_rd = '0;
        mem_wb_reg_write = 1'b0; mem_wb_rd = '0;

        // Reset state
        #2;
        check("rst_pc_write", pc_write, 1);
        check("rst_if_id_write", if_id_write, 1);
        check("rst_if_id_flush", if_id_flush, 0);
        check("rst_bubble", id_ex_bubble, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_fwd_b", fwd_b, 0);
        check("rst_flush_active", flush_active, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // 1. Load-use stall for one cycle
        set_load_use(1'b1);
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_if_id_write", if_id_write, 0);
        check("lu_bubble", id_ex_bubble, 1);
        check("lu_no_flush", if_id_flush, 0);
        check("lu_stall_cnt_before", stall_cnt, 0);
        tick();
        check("lu_stall_cnt_after", stall_cnt, 1);
        check("lu_sat_stall_cnt", s_stall_cnt, 1);
        id_ex_mem_read = 1'b0;
        #1;
        check("lu_release_pc_write", pc_write, 1);
        check("lu_release_bubble", id_ex_bubble, 0);

        // 2. No false stalls
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        check("r0_no_stall", pc_write, 1);
        id_ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1; id_uses_rt = 1'b0;
        #1;
        check("rt_unused_no_stall", pc_write, 1);
        id_uses_rt = 1'b1;
        #1;
        check("rt_used_stall", pc_write, 0);
        id_ex_mem_read = 1'b0; id_uses_rt = 1'b0;
        tick();
        check("stall_cnt_after_rt", stall_cnt, 1);

        // 3. Taken branch, two-cycle flush; load-use in 2nd cycle ignored
        ex_branch_taken = 1'b1;
        #1;
        check("br_c1_flush", if_id_flush, 1);
        check("br_c1_bubble", id_ex_bubble, 1);
        check("br_c1_pc_write", pc_write, 1);
        check("br_c1_flush_active", flush_active, 0);
        tick();
        ex_branch_taken = 1'b0;
        set_load_use(1'b1);
        #1;
        check("br_c2_flush", if_id_flush, 1);
        check("br_c2_flush_active", flush_active, 1);
        check("br_c2_pc_write", pc_write, 1);
        check("br_c2_if_id_write", if_id_write, 1);
        check("br_flush_cnt", flush_cnt, 1);
        id_ex_mem_read = 1'b0;
        tick();
        check("br_c3_flush", if_id_flush, 0);
        check("br_c3_flush_active", flush_active, 0);
        check("br_stall_cnt", stall_cnt, 1);

        // 4. Branch and load-use together: flush wins
        ex_branch_taken = 1'b1;
        set_load_use(1'b1);
        #1;
        check("both_pc_write", pc_write, 1);
        check("both_if_id_write", if_id_write, 1);
        check("both_flush", if_id_flush, 1);
        tick();
        ex_branch_taken = 1'b0;
        id_ex_mem_read = 1'b0;
        #1;
        check("both_stall_cnt", stall_cnt, 1);
        check("both_flush_cnt", flush_cnt, 2);
        tick();

        // 5. Forwarding priority and register-0 suppression
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd3;
        mem_wb_reg_write = 1'b1; mem_wb_rd = 5'd3;
        id_ex_rs = 5'd3; id_ex_rt = 5'd9;
        #1;
        check("fwd_a_exmem", fwd_a, 2'b10);
        check("fwd_b_none", fwd_b, 2'b00);
        ex_mem_reg_write = 1'b0;
        #1;
        check("fwd_a_memwb", fwd_a, 2'b01);
        mem_wb_rd = 5'd0;
        #1;
        check("fwd_a_r0", fwd_a, 2'b00);
        tick();
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd3;
        mem_wb_reg_write = 1'b1; mem_wb_rd = 5'd3;
        id_ex_rs = 5'd12; id_ex_rt = 5'd3;
        #1;
        check("fwd_b_exmem", fwd_b, 2'b10);
        check("fwd_a_none", fwd_a, 2'b00);
        ex_mem_reg_write = 1'b0;
        #1;
        check("fwd_b_memwb", fwd_b, 2'b01);
        mem_wb_rd = 5'd0;
        #1;
        check("fwd_b_r0", fwd_b, 2'b00);
        mem_wb_reg_write = 1'b0; ex_mem_rd = 5'd0; id_ex_rs = 5'd0; id_ex_rt = 5'd0;
        tick();

        // Saturation: 5 more stalls -> 16-bit counter 6, 2-bit counter stuck at 3
        for (int i = 0; i < 5; i++) begin
            set_load_use(1'b1);
            tick();
            id_ex_mem_read = 1'b0;
        end
        check("sat_wide_stall_cnt", stall_cnt, 6);
        check("sat_narrow_stall_cnt", s_stall_cnt, 3);

        // 6. Asynchronous reset in the middle of a flush
        id_ex_rt = 5'd0; id_rs = 5'd0;
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        #1;
        check("midflush_active", flush_active, 1);
        reset = 1'b1;
        #1;
        check("arst_flush_active", flush_active, 0);
        check("arst_if_id_flush", if_id_flush, 0);
        check("arst_bubble", id_ex_bubble, 0);
        check("arst_pc_write", pc_write, 1);
        check("arst_stall_cnt", stall_cnt, 0);
        check("arst_flush_cnt", flush_cnt, 0);
        check("arst_sat_stall_cnt", s_stall_cnt, 0);
        reset = 1'b0;
        tick();
        check("post_rst_flush", if_id_flush, 0);
        check("post_rst_flush_active", flush_active, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
